// File: rtl/pt2262_encoder.sv
// pt2262_encoder: PT2262-style tri-state code-word encoder.
// Serialises twelve 2-bit symbols plus a sync pulse onto dout.
// The frame is repeated REPEAT times for each start request.
//
// Optional feature macro: PT2262_CONT_TX_EN
//   When defined, frames keep repeating past REPEAT for as long as tx_start is
//   still high at the end of each sync. The frame in progress always completes.
//   When undefined, exactly REPEAT frames are sent per start. A tx_start that is
//   high at the final sync end begins a fresh run at once.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | line low, waiting for tx_start
// S_SYMBOL | two 16-alpha pulse cycles for the symbol at r_shift[23:22]
// S_SYNC   | 4 alpha high, 124 alpha low, then next frame / finish

module pt2262_encoder #(
    parameter int ALPHA_DIV = 4,
    parameter int REPEAT    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_start,
    input  logic [23:0] code_word,
    output logic        busy,
    output logic        done,
    output logic        dout
);

    localparam int PRE_W = (ALPHA_DIV > 1) ? $clog2(ALPHA_DIV) : 1;
    localparam int FRM_W = $clog2(REPEAT + 1);

    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(ALPHA_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_REPEAT = FRM_W'(REPEAT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SYMBOL = 2'd1,
        S_SYNC   = 2'd2
    } state_t;

    state_t             r_state;
    logic [PRE_W-1:0]   r_pre;
    logic [6:0]         r_aidx;
    logic [3:0]         r_sym;
    logic [FRM_W-1:0]   r_frame;
    logic [23:0]        r_shift;
    logic [23:0]        r_latch;
    logic               r_dout;
    logic               r_done;

    state_t             w_state_nxt;
    logic [PRE_W-1:0]   w_pre_nxt;
    logic [6:0]         w_aidx_nxt;
    logic [3:0]         w_sym_nxt;
    logic [FRM_W-1:0]   w_frame_nxt;
    logic [23:0]        w_shift_nxt;
    logic [23:0]        w_latch_nxt;
    logic               w_done_nxt;
    logic               w_dout_nxt;

    logic               w_alpha_end;
    logic               w_sym_end;
    logic               w_sync_end;
    logic [FRM_W-1:0]   w_frame_inc;
    logic               w_wide;

    assign w_alpha_end = (r_pre == PRE_LAST);
    assign w_sym_end   = w_alpha_end && (r_aidx == 7'd31);
    assign w_sync_end  = w_alpha_end && (r_aidx == 7'd127);
    assign w_frame_inc = r_frame + FRM_W'(1);

    // State and datapath registers; dout is registered from the next position
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pre   <= '0;
            r_aidx  <= '0;
            r_sym   <= '0;
            r_frame <= '0;
            r_shift <= '0;
            r_latch <= '0;
            r_dout  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pre   <= w_pre_nxt;
            r_aidx  <= w_aidx_nxt;
            r_sym   <= w_sym_nxt;
            r_frame <= w_frame_nxt;
            r_shift <= w_shift_nxt;
            r_latch <= w_latch_nxt;
            r_dout  <= w_dout_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state and counter sequencing
    always_comb begin
        w_state_nxt = r_state;
        w_pre_nxt   = r_pre;
        w_aidx_nxt  = r_aidx;
        w_sym_nxt   = r_sym;
        w_frame_nxt = r_frame;
        w_shift_nxt = r_shift;
        w_latch_nxt = r_latch;
        w_done_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (tx_start) begin
                    w_state_nxt = S_SYMBOL;
                    w_shift_nxt = code_word;
                    w_latch_nxt = code_word;
                    w_pre_nxt   = '0;
                    w_aidx_nxt  = '0;
                    w_sym_nxt   = '0;
                    w_frame_nxt = '0;
                end
            end

            S_SYMBOL: begin
                if (w_alpha_end) begin
                    w_pre_nxt  = '0;
                    w_aidx_nxt = r_aidx + 7'd1;
                end else begin
                    w_pre_nxt  = r_pre + PRE_W'(1);
                end
                if (w_sym_end) begin
                    w_aidx_nxt  = '0;
                    w_shift_nxt = {r_shift[21:0], 2'b00};
                    if (r_sym == 4'd11) begin
                        w_sym_nxt   = '0;
                        w_state_nxt = S_SYNC;
                    end else begin
                        w_sym_nxt   = r_sym + 4'd1;
                    end
                end
            end

            S_SYNC: begin
                if (w_alpha_end) begin
                    w_pre_nxt  = '0;
                    w_aidx_nxt = r_aidx + 7'd1;
                end else begin
                    w_pre_nxt  = r_pre + PRE_W'(1);
                end
                if (w_sync_end) begin
                    w_aidx_nxt = '0;
                    w_sym_nxt  = '0;
                    if (w_frame_inc < FRM_REPEAT) begin
                        // Repeat frames come from the latched copy, never the live input
                        w_frame_nxt = w_frame_inc;
                        w_shift_nxt = r_latch;
                        w_state_nxt = S_SYMBOL;
                    end else begin
`ifdef PT2262_CONT_TX_EN
                        if (tx_start) begin
                            // Frame counter stays saturated while continuing
                            w_shift_nxt = r_latch;
                            w_state_nxt = S_SYMBOL;
                        end else begin
                            w_done_nxt  = 1'b1;
                            w_frame_nxt = '0;
                            w_shift_nxt = '0;
                            w_state_nxt = S_IDLE;
                        end
`else
                        w_done_nxt = 1'b1;
                        if (tx_start) begin
                            // Back-to-back run: latch the new word without passing through idle
                            w_shift_nxt = code_word;
                            w_latch_nxt = code_word;
                            w_frame_nxt = '0;
                            w_state_nxt = S_SYMBOL;
                        end else begin
                            w_frame_nxt = '0;
                            w_shift_nxt = '0;
                            w_state_nxt = S_IDLE;
                        end
`endif
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_pre_nxt   = '0;
                w_aidx_nxt  = '0;
                w_sym_nxt   = '0;
                w_frame_nxt = '0;
            end
        endcase
    end

    // Output decode: line level for the upcoming alpha slot, plus status flags
    always_comb begin
        w_wide     = 1'b0;
        w_dout_nxt = 1'b0;
        case (w_state_nxt)
            S_SYMBOL: begin
                // '1' is wide on both pulses, 'F' only on the second; '0' and reserved stay narrow
                w_wide = (w_shift_nxt[23:22] == 2'b11) ||
                         ((w_shift_nxt[23:22] == 2'b01) && w_aidx_nxt[4]);
                w_dout_nxt = w_wide ? (w_aidx_nxt[3:0] < 4'd12)
                                    : (w_aidx_nxt[3:0] < 4'd4);
            end
            S_SYNC: begin
                w_dout_nxt = (w_aidx_nxt < 7'd4);
            end
            default: begin
                w_dout_nxt = 1'b0;
            end
        endcase

        busy = (r_state != S_IDLE);
        done = r_done;
        dout = r_dout;
    end

endmodule

// File: tb/tb_pt2262_encoder.sv
// Testbench for pt2262_encoder.
// The expected per-cycle (dout, busy, done) stream is built from the symbol
// waveform definitions and queued when each run is started.
// It is then popped and compared one clock at a time.
// Optional feature macro: PT2262_CONT_TX_EN (changes the hold-start expectation).

module tb_pt2262_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx;
    logic        sel;
    logic [23:0] cw;

    logic a_busy, a_done, a_dout;
    logic b_busy, b_done, b_dout;
    logic w_tx_a, w_tx_b;
    logic w_busy, w_done, w_dout;

    assign w_tx_a = tx & ~sel;
    assign w_tx_b = tx & sel;
    assign w_busy = sel ? b_busy : a_busy;
    assign w_done = sel ? b_done : a_done;
    assign w_dout = sel ? b_dout : a_dout;

    pt2262_encoder #(.ALPHA_DIV(2), .REPEAT(1)) dut_a (
        .clk(clk), .rst(rst), .tx_start(w_tx_a), .code_word(cw),
        .busy(a_busy), .done(a_done), .dout(a_dout)
    );

    pt2262_encoder #(.ALPHA_DIV(1), .REPEAT(4)) dut_b (
        .clk(clk), .rst(rst), .tx_start(w_tx_b), .code_word(cw),
        .busy(b_busy), .done(b_done), .dout(b_dout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic dout;
        logic busy;
        logic done;
    } exp_t;

    typedef struct {
        logic [23:0] cw;
        int          exp_busy;
        int          exp_hi0;
    } vec_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc, busy_n, done_n, hi0;
    bit   in_hi0;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic push_level(input logic v, input int n);
        exp_t e;
        e.dout = v;
        e.busy = 1'b1;
        e.done = 1'b0;
        for (int i = 0; i < n; i++) q.push_back(e);
    endtask

    // One run of 'frames' frames built straight from the pulse definitions
    task automatic push_run(input logic [23:0] w, input int ad, input int frames);
        logic [1:0] s;
        bit         wide;
        int         hi;
        for (int f = 0; f < frames; f++) begin
            for (int k = 0; k < 12; k++) begin
                s = w[23-2*k -: 2];
                for (int p = 0; p < 2; p++) begin
                    wide = (s == 2'b11) || (s == 2'b01 && p == 1);
                    hi   = wide ? 12 : 4;
                    push_level(1'b1, hi * ad);
                    push_level(1'b0, (16 - hi) * ad);
                end
            end
            push_level(1'b1, 4 * ad);
            push_level(1'b0, 124 * ad);
        end
    endtask

    task automatic push_tail();
        exp_t e;
        e = '{dout: 1'b0, busy: 1'b0, done: 1'b1};
        q.push_back(e);
        e = '{dout: 1'b0, busy: 1'b0, done: 1'b0};
        q.push_back(e);
    endtask

    task automatic mark_done(input int idx);
        exp_t e;
        e = q[idx];
        e.done = 1'b1;
        q[idx] = e;
    endtask

    task automatic reset_stats();
        cyc    = 0;
        busy_n = 0;
        done_n = 0;
        hi0    = 0;
        in_hi0 = 1'b1;
    endtask

    task automatic cmp_cycle(input string nm);
        exp_t e, g;
        @(posedge clk);
        #1;
        e = q.pop_front();
        g = {w_dout, w_busy, w_done};
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s cyc=%0d got(dout,busy,done)=%b exp=%b", nm, cyc, g, e);
        end
        if (w_busy) busy_n++;
        if (w_done) done_n++;
        if (in_hi0 && w_dout) hi0++;
        else in_hi0 = 1'b0;
        cyc++;
    endtask

    // Compare until the queue is empty; optional tx release point and mid-run disturbance
    task automatic drain(input string nm, input int hold_until, input int pert_at,
                         input logic [23:0] pert_cw);
        int c;
        while (q.size() > 0) begin
            cmp_cycle(nm);
            c = cyc - 1;
            if (c == hold_until) tx = 1'b0;
            if (c == pert_at) begin
                cw = pert_cw;
                tx = 1'b1;
            end
            if (pert_at >= 0 && c == pert_at + 3) tx = 1'b0;
        end
    endtask

    vec_t tbl[5];
    int   m;

    initial begin
        tbl[0] = '{cw: 24'h000000, exp_busy: 1024, exp_hi0: 8};
        tbl[1] = '{cw: 24'hC40000, exp_busy: 1024, exp_hi0: 24};
        tbl[2] = '{cw: 24'h5A5A5A, exp_busy: 1024, exp_hi0: 8};
        tbl[3] = '{cw: 24'hFFFFFF, exp_busy: 1024, exp_hi0: 24};
        tbl[4] = '{cw: 24'h9B0C27, exp_busy: 1024, exp_hi0: 8};

        rst = 1'b1;
        tx  = 1'b0;
        sel = 1'b0;
        cw  = 24'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout", int'(w_dout), 0);
        chk("rst_busy", int'(w_busy), 0);
        chk("rst_done", int'(w_done), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_busy", int'(w_busy), 0);

        // Table of single-frame words
        for (int i = 0; i < 5; i++) begin
            cw = tbl[i].cw;
            reset_stats();
            push_run(tbl[i].cw, 2, 1);
            push_tail();
            tx = 1'b1;
            drain("vec_wave", 0, -1, 24'h0);
            chk("vec_busy_len", busy_n, tbl[i].exp_busy);
            chk("vec_done_cnt", done_n, 1);
            chk("vec_first_hi", hi0, tbl[i].exp_hi0);
        end

        // Word change and start pulse while busy are ignored
        cw = 24'hC40000;
        reset_stats();
        push_run(24'hC40000, 2, 1);
        push_tail();
        tx = 1'b1;
        drain("latch_wave", 0, 100, 24'hFFFFFF);
        chk("latch_busy_len", busy_n, 1024);
        chk("latch_done_cnt", done_n, 1);

        // Asynchronous reset in the middle of a symbol, then a clean restart
        cw = 24'h000000;
        reset_stats();
        push_run(24'h000000, 2, 1);
        tx = 1'b1;
        for (int i = 0; i < 37; i++) begin
            cmp_cycle("prerst_wave");
            if (i == 0) tx = 1'b0;
        end
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_dout", int'(w_dout), 0);
        chk("midrst_busy", int'(w_busy), 0);
        chk("midrst_done", int'(w_done), 0);
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cw = 24'hC40000;
        reset_stats();
        push_run(24'hC40000, 2, 1);
        push_tail();
        tx = 1'b1;
        drain("postrst_wave", 0, -1, 24'h0);
        chk("postrst_first_hi", hi0, 24);
        chk("postrst_busy_len", busy_n, 1024);

        // REPEAT=4, ALPHA_DIV=1 instance
        sel = 1'b1;
        cw  = 24'hFFFFFF;
        reset_stats();
        push_run(24'hFFFFFF, 1, 4);
        push_tail();
        tx = 1'b1;
        drain("rep4_wave", 0, -1, 24'h0);
        chk("rep4_busy_len", busy_n, 2048);
        chk("rep4_done_cnt", done_n, 1);
        chk("rep4_first_hi", hi0, 12);

        // tx_start held across three frame times
        sel = 1'b0;
        cw  = 24'h3C0F50;
        reset_stats();
`ifdef PT2262_CONT_TX_EN
        push_run(24'h3C0F50, 2, 3);
`else
        push_run(24'h3C0F50, 2, 1);
        m = q.size();
        push_run(24'h3C0F50, 2, 1);
        mark_done(m);
        m = q.size();
        push_run(24'h3C0F50, 2, 1);
        mark_done(m);
`endif
        push_tail();
        tx = 1'b1;
        drain("hold_wave", 2548, -1, 24'h0);
        chk("hold_busy_len", busy_n, 3072);
`ifdef PT2262_CONT_TX_EN
        chk("hold_done_cnt", done_n, 1);
`else
        chk("hold_done_cnt", done_n, 3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pt2262_encoder.md
# pt2262_encoder

- Transmit-side tri-state code-word encoder, the PT2262 counterpart of the PT2272 decoder path.
- Accepts a 12-symbol code word (address/data trits, 2 bits per symbol) and serialises it onto a single line `dout` as PT2262 pulse-width waveforms, followed by a sync symbol.
- Repeats the frame a configurable number of times.
- Sits in front of the RF/line model and feeds the decoder's input in loopback benches.

## Interface

Parameters:
- `ALPHA_DIV`, default 4: clock cycles per oscillator period α; legal range ≥1.
- `REPEAT`, default 4: frames sent per start; legal range ≥1.

Ports:
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: reset, asynchronous, active-high.
- `tx_start` input, 1 bit: start request, sampled in IDLE only.
- `code_word` input, 24 bits: symbol k occupies `[23-2k:22-2k]`; symbol 0 is sent first.
- `busy` output, 1 bit: high while frames are in progress.
- `done` output, 1 bit: one-cycle pulse when the last frame completes.
- `dout` output, 1 bit: serial encoded waveform.

## Operation

- Symbol encoding: 2'b00 is '0', 2'b11 is '1', 2'b01 is 'F' (floating). 2'b10 is reserved and transmitted as '0'.
- Pulse cycle is 16α:
  - narrow (N): 4α high, 12α low.
  - wide (W): 12α high, 4α low.
- Symbol waveforms (each symbol is 32α):
  - '0' = N,N
  - '1' = W,W
  - 'F' = N,W
- Sync: 4α high, then 124α low (128α total).
- Frame: symbols 0..11 followed by sync, 512α total.
- FSM states:
  - IDLE: `tx_start`=1 → SYMBOL. `code_word` is latched into an internal 24-bit shift register; symbol counter and frame counter are cleared.
  - SYMBOL: emits the two pulse cycles of the symbol at register bits [23:22]. At the end, shift left by 2 and increment the symbol counter. After symbol 11 → SYNC.
  - SYNC: emits sync. At the end, increment the frame counter.
    - If frames < REPEAT → SYMBOL, reloading the shift register from the latched copy, not from the live `code_word`.
    - Otherwise → IDLE with `done`=1.
- Counters:
  - α prescaler: 0..ALPHA_DIV-1.
  - α index within the symbol: 0..31, or 0..127 in SYNC.
  - Symbol counter: 0..11.
  - Frame counter: sized to hold REPEAT.
- `tx_start` is ignored while `busy`=1. Changes to `code_word` after the start edge have no effect on the frames in progress.

## Timing

- Reset values: `dout`=0, `busy`=0, `done`=0, state IDLE, all counters 0. Reset takes effect immediately, including mid-frame; `dout` drops low asynchronously.
- Start latency: `tx_start` sampled high in IDLE at edge E → `busy`=1 and `dout`=1 from edge E. This is the first α of symbol 0.
- `dout` is registered, with no glitches. Each α lasts exactly ALPHA_DIV clocks.
- A run lasts exactly REPEAT×512×ALPHA_DIV clocks of `busy`=1.
- On the edge ending the final sync:
  - `busy`=0, `done`=1 for one cycle, `dout`=0.
- Back-to-back runs: `tx_start` high in the same cycle as `done` is sampled on that edge and starts a new run immediately. In that case `busy` stays high and `done` still pulses.
- Frames in a run are contiguous, with no gap between a sync and the next symbol 0.

## Configuration

- Macro `PT2262_CONT_TX_EN`.
- Defined:
  - After REPEAT frames, keep sending frames while `tx_start` is still high at the end of each sync.
  - When `tx_start` is low at a sync end, finish and pulse `done`.
  - The frame in progress is always completed.
- Undefined: exactly REPEAT frames per start, regardless of the `tx_start` level.

## Test plan

All scenarios use ALPHA_DIV=2 and REPEAT=1 unless stated otherwise.

- Reset: `rst` pulsed mid-symbol → `dout`/`busy`/`done` are 0 within the same cycle. Then `tx_start` → a clean frame starts at symbol 0.
- All-'0' word: `code_word`=24'h000000 → 24 repetitions of 8 clocks high / 24 clocks low, then 8 high / 248 low. `busy` lasts 1024 clocks, then one `done` pulse.
- Mixed word: `code_word`=24'hC40000 (symbols 1,0,F,0…) → first symbol W,W (24h/8l ×2), second N,N, third N,W.
- Latch and ignore: change `code_word` and pulse `tx_start` while `busy` → waveform unchanged; no second run starts.
- REPEAT=4, ALPHA_DIV=1, word 24'hFFFFFF → 4 identical contiguous frames of 512 clocks. `busy` lasts 2048 clocks with a single `done`.
- With `PT2262_CONT_TX_EN`, REPEAT=1: hold `tx_start` for 3 frames → exactly 3 frames, then `done`. Without the macro, the same stimulus gives 1 frame per start; back-to-back restarts happen on the `done` cycles.
